// File: rtl/mem_access_unit.sv
// Memory-access stage: one LOAD/STORE bus transaction per start, with lane steering and load extension.
// Optional MEM_MISALIGN_TRAP_EN: report misaligned half/word accesses instead of aligning them down.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  ready_o,
  input  logic                  is_store_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misaligned_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_RESP} state_e;
  state_e r_state, w_next;

  logic                  w_accept, w_byte, w_half, w_mis;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_shift, w_ext;

  logic                  r_store, r_byte, r_half, r_uns;
  logic [1:0]            r_off;
  logic                  r_req, r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;

  assign w_accept = start_i && (r_state == S_IDLE);
  // LBU/LHU encodings are loads only; as stores they fall back to word
  assign w_byte = (funct3_i == 3'b000) || (!is_store_i && funct3_i == 3'b100);
  assign w_half = (funct3_i == 3'b001) || (!is_store_i && funct3_i == 3'b101);

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_mis = (w_half && addr_i[0]) || (!w_byte && !w_half && addr_i[1:0] != 2'b00);
  assign w_off = addr_i[1:0];
  assign misaligned_o = r_mis;
`else
  assign w_mis = 1'b0;
  assign w_off = w_byte ? addr_i[1:0] : (w_half ? {addr_i[1], 1'b0} : 2'b00);
  assign misaligned_o = 1'b0;
`endif

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_i;
    if (w_byte) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{wdata_i[7:0]}};
    end else if (w_half) begin
      w_be    = 4'b0011 << w_off;
      w_wdata = {2{wdata_i[15:0]}};
    end
  end

  assign w_shift = mem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shift;
    if (r_byte)      w_ext = {{24{w_shift[7]  & ~r_uns}}, w_shift[7:0]};
    else if (r_half) w_ext = {{16{w_shift[15] & ~r_uns}}, w_shift[15:0]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i)      w_next = w_mis ? S_RESP : S_REQ;
      S_REQ:    if (mem_gnt_i)    w_next = r_store ? S_RESP : S_WAIT_R;
      S_WAIT_R: if (mem_rvalid_i) w_next = S_RESP;
      S_RESP:                     w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_store <= 1'b0;
      r_byte  <= 1'b0;
      r_half  <= 1'b0;
      r_uns   <= 1'b0;
      r_off   <= 2'b00;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'b0000;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_mis   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_store <= is_store_i;
      r_byte  <= w_byte;
      r_half  <= w_half;
      r_uns   <= funct3_i[2];
      r_off   <= w_off;
      r_req   <= !w_mis;
      r_we    <= is_store_i && !w_mis;
      r_addr  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_rdata <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_mis   <= w_mis;
`endif
    end else if (r_state == S_REQ && mem_gnt_i) begin
      r_req <= 1'b0;
      r_we  <= 1'b0;
    end else if (r_state == S_WAIT_R && mem_rvalid_i) begin
      r_rdata <= w_ext;
    end
  end

  assign ready_o     = (r_state == S_IDLE);
  assign done_o      = (r_state == S_RESP);
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_be_o    = r_be;
  assign mem_wdata_o = r_wdata;
  assign rdata_o     = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table driven through a scripted bus, scoreboard checks completions.
module tb_mem_access_unit;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_store = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;
  logic        done, mis_o;
  logic [31:0] rdata_o;

  int n_tests = 0, n_fail = 0;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ready_o(ready),
    .is_store_i(is_store), .funct3_i(f3), .addr_i(addr), .wdata_i(wdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .done_o(done), .rdata_o(rdata_o), .misaligned_o(mis_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st; logic [2:0] f3; logic [31:0] addr, wdata, rdata;
    int gd, rd; bit busy, rvg;
    bit mis; logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wd, e_rd; bit chk_rd; int lat;
  } vec_t;
  typedef struct { logic [31:0] rd; bit mis; bit chk_rd; int lat; } exp_t;

  exp_t sb[$];
  vec_t tv[12];

  function automatic vec_t mk(logic st, logic [2:0] f, logic [31:0] a, logic [31:0] wd, logic [31:0] rdw,
                              int gd, int rd, bit busy, bit rvg, bit mis, logic [31:0] ea,
                              logic [3:0] ebe, logic [31:0] ewd, logic [31:0] erd, bit chk_rd, int lat);
    vec_t v;
    v.st = st; v.f3 = f; v.addr = a; v.wdata = wd; v.rdata = rdw; v.gd = gd; v.rd = rd;
    v.busy = busy; v.rvg = rvg; v.mis = mis; v.e_addr = ea; v.e_be = ebe; v.e_wd = ewd;
    v.e_rd = erd; v.chk_rd = chk_rd; v.lat = lat;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(string nm, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    exp_t e;
    int cyc, rq, wt;
    bit gr, fin;
    @(posedge clk); #1;
    chkb($sformatf("v%0d ready_idle", idx), ready, 1'b1);
    start = 1'b1; is_store = v.st; f3 = v.f3; addr = v.addr; wdata = v.wdata;
    e.rd = v.e_rd; e.mis = v.mis; e.chk_rd = v.chk_rd; e.lat = v.lat;
    sb.push_back(e);
    @(posedge clk); #1;
    cyc = 1; rq = 0; wt = 0; gr = 1'b0; fin = 1'b0;
    if (!v.busy) start = 1'b0;
    chkb($sformatf("v%0d ready_busy", idx), ready, 1'b0);
    while (!fin && cyc < 60) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (v.busy) begin addr = $urandom; wdata = $urandom; end
      if (done) begin
        start = 1'b0;
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL v%0d scoreboard: done with no pending access", idx);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d latency", idx), cyc, e.lat);
          chkb($sformatf("v%0d misaligned", idx), mis_o, e.mis);
          if (e.chk_rd) chk($sformatf("v%0d rdata", idx), rdata_o, e.rd);
        end
        fin = 1'b1;
      end else begin
        if (mem_req && v.mis) chkb($sformatf("v%0d req_on_misalign", idx), mem_req, 1'b0);
        else if (mem_req && !gr) begin
          chk($sformatf("v%0d addr", idx), mem_addr, v.e_addr);
          chk($sformatf("v%0d be", idx), 32'(mem_be), 32'(v.e_be));
          chk($sformatf("v%0d wdata", idx), mem_wdata, v.e_wd);
          chkb($sformatf("v%0d we", idx), mem_we, v.st);
          if (rq == v.gd) begin
            mem_gnt = 1'b1; gr = 1'b1;
            if (v.rvg) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0; end
          end
          rq++;
        end else if (gr && !v.st) begin
          if (wt == v.rd) begin mem_rvalid = 1'b1; mem_rdata = v.rdata; end
          wt++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; start = 1'b0;
    if (!fin) begin
      n_tests++; n_fail++;
      $display("FAIL v%0d timeout: no done after %0d cycles, required latency %0d", idx, cyc, v.lat);
    end
    @(posedge clk); #1;
    chkb($sformatf("v%0d done_pulse", idx), done, 1'b0);
    chkb($sformatf("v%0d ready_after", idx), ready, 1'b1);
    chkb($sformatf("v%0d req_after", idx), mem_req, 1'b0);
  endtask

  initial begin
    tv[0]  = mk(0, 3'b000, 32'h1003, 0, 32'h80AABBCC, 0, 0, 0, 0, 0, 32'h1000, 4'b1000, 0, 32'hFFFFFF80, 1, 3);
    tv[1]  = mk(1, 3'b001, 32'h2002, 32'h1234ABCD, 0, 3, 0, 0, 0, 0, 32'h2000, 4'b1100, 32'hABCDABCD, 0, 0, 5);
    tv[2]  = mk(0, 3'b101, 32'h3002, 0, 32'hF00D0000, 0, 0, 1, 0, 0, 32'h3000, 4'b1100, 0, 32'h0000F00D, 1, 3);
`ifdef MEM_MISALIGN_TRAP_EN
    tv[3]  = mk(0, 3'b010, 32'h4001, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 32'h0, 1, 1);
    tv[9]  = mk(1, 3'b001, 32'hA001, 32'h00005A5A, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 32'h0, 1, 1);
`else
    tv[3]  = mk(0, 3'b010, 32'h4001, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h4000, 4'b1111, 0, 32'hDEADBEEF, 1, 3);
    tv[9]  = mk(1, 3'b001, 32'hA001, 32'h00005A5A, 0, 0, 0, 0, 0, 0, 32'hA000, 4'b0011, 32'h5A5A5A5A, 0, 0, 2);
`endif
    tv[4]  = mk(1, 3'b000, 32'h5001, 32'h000000A5, 0, 0, 0, 0, 0, 0, 32'h5000, 4'b0010, 32'hA5A5A5A5, 0, 0, 2);
    tv[5]  = mk(0, 3'b001, 32'h6002, 0, 32'h80011234, 1, 2, 0, 1, 0, 32'h6000, 4'b1100, 0, 32'hFFFF8001, 1, 6);
    tv[6]  = mk(0, 3'b100, 32'h7001, 0, 32'h1234F0AB, 0, 1, 0, 0, 0, 32'h7000, 4'b0010, 0, 32'h000000F0, 1, 4);
    tv[7]  = mk(1, 3'b010, 32'h8000, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 32'h8000, 4'b1111, 32'hCAFEF00D, 0, 0, 2);
    tv[8]  = mk(0, 3'b010, 32'h9000, 0, 32'h7FFF0001, 2, 3, 0, 0, 0, 32'h9000, 4'b1111, 0, 32'h7FFF0001, 1, 8);
    tv[10] = mk(0, 3'b000, 32'hB000, 0, 32'h0000007F, 0, 0, 0, 0, 0, 32'hB000, 4'b0001, 0, 32'h0000007F, 1, 3);
    tv[11] = mk(0, 3'b110, 32'hC000, 0, 32'h89ABCDEF, 0, 0, 0, 0, 0, 32'hC000, 4'b1111, 0, 32'h89ABCDEF, 1, 3);

    // reset held with start asserted: unit stays idle and quiet
    start = 1'b1; is_store = 1'b1; f3 = 3'b010; addr = 32'h40; wdata = 32'h11223344;
    repeat (2) @(posedge clk);
    #1;
    chkb("rst ready", ready, 1'b1);
    chkb("rst req", mem_req, 1'b0);
    chkb("rst we", mem_we, 1'b0);
    chkb("rst done", done, 1'b0);
    chkb("rst mis", mis_o, 1'b0);
    chk("rst addr", mem_addr, 0);
    chk("rst be", 32'(mem_be), 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst rdata", rdata_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chkb("first accept req", mem_req, 1'b1);
    chk("first accept addr", mem_addr, 32'h40);
    chk("first accept wdata", mem_wdata, 32'h11223344);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chkb("first accept done", done, 1'b1);

    for (int i = 0; i < 12; i++) run(tv[i], i);

    // reset while waiting for grant: request drops without a clock edge
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; f3 = 3'b010; addr = 32'hD000;
    @(posedge clk); #1;
    start = 1'b0;
    chkb("midrst req_before", mem_req, 1'b1);
    rst_n = 1'b0; #1;
    chkb("midrst req_async", mem_req, 1'b0);
    chkb("midrst ready_async", ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // reset in WAIT_R; a late rvalid must not complete anything
    @(posedge clk); #1;
    start = 1'b1; addr = 32'hE004;
    @(posedge clk); #1;
    start = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chkb("waitr ready_before", ready, 1'b0);
    rst_n = 1'b0; #1;
    chkb("waitr req", mem_req, 1'b0);
    chkb("waitr ready", ready, 1'b1);
    chkb("waitr done", done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chkb($sformatf("waitr no_done%0d", i), done, 1'b0);
      @(posedge clk); #1;
    end
    chkb("waitr ready_end", ready, 1'b1);
    chk("sb drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Memory-access stage of the multi-cycle core, directly downstream of the ALU.
- Takes the effective address computed by the ALU for LOAD/STORE opcodes and runs one data-memory transaction over a request/grant/response bus.
- Performs byte-lane steering, byte-enable generation and load sign/zero extension.
- Returns a one-cycle completion pulse, with load data, to the control FSM.

## Interface

Parameters:
- ADDR_WIDTH, 32, width of the effective address and memory address.
- DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; asynchronous, active-low.
- start_i  in  1  control FSM requests an access; sampled only when ready_o=1.
- ready_o  out  1  unit idle and able to accept start_i.
- is_store_i  in  1  1 = store, 0 = load.
- funct3_i  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr_i  in  ADDR_WIDTH  effective address (ALU result).
- wdata_i  in  DATA_WIDTH  store data (rs2), right-aligned.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  ADDR_WIDTH  word-aligned address, with bits [1:0] = 0.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  DATA_WIDTH  lane-steered store data.
- mem_gnt_i  in  1  bus accepts the request in this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_WIDTH  read word.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  DATA_WIDTH  extended load result; valid while done_o=1, held until the next accept.
- misaligned_o  out  1  valid with done_o; access was misaligned and no bus transaction took place.

## Operation

States: IDLE, REQ, WAIT_R, RESP.

IDLE:
- ready_o=1.
- On start_i, latch is_store_i, funct3_i, addr_i and wdata_i.
- Compute alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
- If misaligned: go to RESP with misaligned flag set.
- Otherwise: go to REQ.

REQ:
- mem_req_o=1; address, byte enables, we and wdata are driven from the latched values and held stable until grant.
- On mem_gnt_i: a store goes to RESP; a load goes to WAIT_R.

WAIT_R:
- On mem_rvalid_i, capture mem_rdata_i, then go to RESP.
- rvalid in the same cycle as gnt is not legal; it is ignored in REQ.

RESP:
- done_o=1 for one cycle, then return to IDLE.

Byte enables and store lanes (o = addr[1:0]):
- Byte: be = 0001<<o; wdata = {4{wdata[7:0]}}.
- Half: be = 0011<<o; wdata = {2{wdata[15:0]}}.
- Word: be = 1111; wdata = wdata.
- Loads drive be for the accessed lanes as well.

Load extraction:
- Shift the read word right by 8*o.
- LB/LH sign-extend from bit 7/15.
- LBU/LHU zero-extend.
- LW passes the word through.
- Unsupported funct3 is treated as LW/SW.

## Timing

- Reset values: FSM in IDLE; ready_o=1; mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0; done_o=0; rdata_o=0; misaligned_o=0.
- Accept cycle T (start_i with ready_o=1): mem_req_o rises at T+1.
- Store with immediate grant: done_o at T+2.
- Load with gnt at T+1 and rvalid at T+2: done_o at T+3.
- Misaligned access: done_o at T+1; mem_req_o is never asserted.
- ready_o=0 from T+1 until the cycle after done_o. start_i while busy is ignored.
- Grant and rvalid may each be delayed any number of cycles; the unit waits indefinitely.
- mem_* outputs are registered, with no combinational paths from the bus inputs.
- Reset asserted mid-transaction: return to IDLE immediately and drop mem_req_o asynchronously. Any outstanding bus response is the bus's responsibility.

## Configuration

MEM_MISALIGN_TRAP_EN:
- Defined: misaligned halfword/word accesses are not issued; done_o is returned with misaligned_o=1 and rdata_o=0.
- Undefined: misalignment is never flagged (misaligned_o is tied 0). The offset is forced down to natural alignment (addr[0] cleared for halfword, addr[1:0] cleared for word) and the access proceeds normally.

## Test plan

- Reset: hold rst_ni=0 with start_i=1 -> ready_o=1, mem_req_o=0, done_o=0; after release, the first start_i is accepted.
- LB at addr 0x1003, rdata 0x80AABBCC, gnt at T+1, rvalid at T+2 -> mem_addr_o=0x1000, mem_be_o=1000, rdata_o=0xFFFFFF80, done_o at T+3.
- SH at addr 0x2002, wdata 0x1234ABCD, gnt delayed 3 cycles -> mem_be_o=1100, mem_wdata_o=0xABCDABCD held stable until gnt, mem_we_o=1, done_o one cycle after gnt.
- LHU at 0x3002, rdata 0xF00D0000 -> rdata_o=0x0000F00D; a back-to-back start_i asserted during the busy cycles is ignored.
- LW at 0x4001 -> with MEM_MISALIGN_TRAP_EN: done_o at T+1, misaligned_o=1, no mem_req_o. Without it: mem_addr_o=0x4000, mem_be_o=1111, normal load.
- Reset asserted while in WAIT_R -> mem_req_o=0 and ready_o=1 immediately; a later rvalid produces no done_o.
